// File: rtl/hazard_pkg.sv
// Shared types for the load hazard unit: FSM state encoding and register index type.
package hazard_pkg;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUBBLE = 2'd1,
        WAIT   = 2'd2
    } hazard_state_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/pending_scoreboard.sv
// Outstanding-load table: per-register pending bitmap plus in-flight count.
// An issue/done pair on the same register keeps the bit set because the issue is the newer load.
module pending_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS        = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                loadIssue,
    input  reg_idx_t            loadDest,
    input  logic                loadDone,
    input  reg_idx_t            loadDoneDest,
    output logic [NUM_REGS-1:0] pending,
    output logic                full
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [CW-1:0]       count;
    logic [CW-1:0]       nextCount;
    logic [NUM_REGS-1:0] nextPending;
    logic                issueOk;
    logic                doneOk;

    assign full = (count == CW'(MAX_OUTSTANDING));

    always_comb begin
        doneOk      = loadDone && (count != '0);
        // A completion in the same cycle frees a slot, so a full table can still take the issue.
        issueOk     = loadIssue && (!full || doneOk);
        nextPending = pending;
        nextCount   = count;
        if (doneOk)
            nextPending = nextPending & ~(NUM_REGS'(1) << loadDoneDest);
        if (issueOk && (loadDest != REG_ZERO))
            nextPending = nextPending | (NUM_REGS'(1) << loadDest);
        case ({issueOk, doneOk})
            2'b10:   nextCount = count + CW'(1);
            2'b01:   nextCount = count - CW'(1);
            default: nextCount = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending <= '0;
            count   <= '0;
        end else begin
            pending <= nextPending;
            count   <= nextCount;
        end
    end

    issueWhileFull: assert property (@(posedge clk) disable iff (!reset)
        !(loadIssue && full && !loadDone));

    doneWhileEmpty: assert property (@(posedge clk) disable iff (!reset)
        !(loadDone && (count == '0)));

endmodule

// File: rtl/load_hazard_unit.sv
// Load-use / multi-cycle load hazard detection driving stall and bubble controls.
// Optional HAZARD_PERF_COUNTERS_EN adds load-use and wait-cycle counters.
module load_hazard_unit
    import hazard_pkg::*;
#(
    parameter int NUM_REGS        = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inDecodeValid,
    input  reg_idx_t            inRegisterRs,
    input  reg_idx_t            inRegisterRt,
    input  logic                inUsesRs,
    input  logic                inUsesRt,
    input  logic                inMemReadEx,
    input  reg_idx_t            inDestRegisterEx,
    input  logic                inLoadIssue,
    input  reg_idx_t            inLoadDest,
    input  logic                inLoadDone,
    input  reg_idx_t            inLoadDoneDest,
    input  logic                inBranchFlush,
    output logic                outStallIf,
    output logic                outStallId,
    output logic                outBubbleEx,
    output logic                outIssueBlock,
    output logic [NUM_REGS-1:0] outPending
`ifdef HAZARD_PERF_COUNTERS_EN
    ,
    output logic [31:0]         outLoadUseCount,
    output logic [31:0]         outWaitCycleCount
`endif
);

    hazard_state_t       state;
    hazard_state_t       nextState;
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] livePending;
    logic                full;
    logic                rsLive;
    logic                rtLive;
    logic                loadUse;
    logic                pendHit;
    logic                stall;

    pending_scoreboard #(
        .NUM_REGS        (NUM_REGS),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) uScoreboard (
        .clk          (clk),
        .reset        (reset),
        .loadIssue    (inLoadIssue),
        .loadDest     (inLoadDest),
        .loadDone     (inLoadDone),
        .loadDoneDest (inLoadDoneDest),
        .pending      (pending),
        .full         (full)
    );

    assign rsLive = inDecodeValid && inUsesRs && (inRegisterRs != REG_ZERO);
    assign rtLive = inDecodeValid && inUsesRt && (inRegisterRt != REG_ZERO);

    // A load completing this cycle is served by the WB bypass, so its bit no longer hazards.
    assign livePending = inLoadDone ? (pending & ~(NUM_REGS'(1) << inLoadDoneDest)) : pending;

    assign loadUse = inMemReadEx && ((rsLive && (inRegisterRs == inDestRegisterEx)) ||
                                     (rtLive && (inRegisterRt == inDestRegisterEx)));
    assign pendHit = (rsLive && livePending[inRegisterRs]) ||
                     (rtLive && livePending[inRegisterRt]);

    assign stall = reset && !inBranchFlush && (loadUse || pendHit);

    assign outStallIf    = stall;
    assign outStallId    = stall;
    assign outBubbleEx   = stall;
    assign outIssueBlock = reset && full;
    assign outPending    = reset ? pending : '0;

    always_comb begin
        nextState = state;
        if (inBranchFlush) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (loadUse)      nextState = BUBBLE;
                    else if (pendHit) nextState = WAIT;
                end
                BUBBLE:  nextState = pendHit ? WAIT : IDLE;
                WAIT:    nextState = pendHit ? WAIT : IDLE;
                default: nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [31:0] loadUseCount;
    logic [31:0] waitCycleCount;

    always_ff @(posedge clk) begin
        if (!reset) begin
            loadUseCount   <= '0;
            waitCycleCount <= '0;
        end else begin
            if (state == IDLE && nextState == BUBBLE) loadUseCount <= loadUseCount + 32'd1;
            if (state == WAIT)                        waitCycleCount <= waitCycleCount + 32'd1;
        end
    end

    assign outLoadUseCount   = reset ? loadUseCount : '0;
    assign outWaitCycleCount = reset ? waitCycleCount : '0;
`endif

endmodule

// File: tb/tb_load_hazard_unit.sv
// Directed vector bench for load_hazard_unit: one long per-cycle table plus a flush/load-use sequence.
module tb_load_hazard_unit;
    import hazard_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        inDecodeValid;
    reg_idx_t    inRegisterRs, inRegisterRt;
    logic        inUsesRs, inUsesRt;
    logic        inMemReadEx;
    reg_idx_t    inDestRegisterEx;
    logic        inLoadIssue;
    reg_idx_t    inLoadDest;
    logic        inLoadDone;
    reg_idx_t    inLoadDoneDest;
    logic        inBranchFlush;
    logic        outStallIf, outStallId, outBubbleEx, outIssueBlock;
    logic [31:0] outPending;
`ifdef HAZARD_PERF_COUNTERS_EN
    logic [31:0] outLoadUseCount, outWaitCycleCount;
`endif

    int passCount = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    load_hazard_unit #(.NUM_REGS(32), .MAX_OUTSTANDING(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .inDecodeValid    (inDecodeValid),
        .inRegisterRs     (inRegisterRs),
        .inRegisterRt     (inRegisterRt),
        .inUsesRs         (inUsesRs),
        .inUsesRt         (inUsesRt),
        .inMemReadEx      (inMemReadEx),
        .inDestRegisterEx (inDestRegisterEx),
        .inLoadIssue      (inLoadIssue),
        .inLoadDest       (inLoadDest),
        .inLoadDone       (inLoadDone),
        .inLoadDoneDest   (inLoadDoneDest),
        .inBranchFlush    (inBranchFlush),
        .outStallIf       (outStallIf),
        .outStallId       (outStallId),
        .outBubbleEx      (outBubbleEx),
        .outIssueBlock    (outIssueBlock),
        .outPending       (outPending)
`ifdef HAZARD_PERF_COUNTERS_EN
        ,
        .outLoadUseCount  (outLoadUseCount),
        .outWaitCycleCount(outWaitCycleCount)
`endif
    );

    typedef struct {
        string         name;
        logic          rstN, dv, usesRs, usesRt, memEx, issue, done, flush;
        reg_idx_t      rs, rt, destEx, loadDest, doneDest;
        logic          expStall, expBlock;
        logic [31:0]   expPend;
        hazard_state_t expState;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic rstN, logic dv,
                                logic usesRs, reg_idx_t rs, logic usesRt, reg_idx_t rt,
                                logic memEx, reg_idx_t destEx,
                                logic issue, reg_idx_t loadDest,
                                logic done, reg_idx_t doneDest, logic flush,
                                logic expStall, logic expBlock, logic [31:0] expPend,
                                hazard_state_t expState);
        vec_t v;
        v.name = name; v.rstN = rstN; v.dv = dv;
        v.usesRs = usesRs; v.rs = rs; v.usesRt = usesRt; v.rt = rt;
        v.memEx = memEx; v.destEx = destEx;
        v.issue = issue; v.loadDest = loadDest;
        v.done = done; v.doneDest = doneDest; v.flush = flush;
        v.expStall = expStall; v.expBlock = expBlock; v.expPend = expPend; v.expState = expState;
        return v;
    endfunction

    function automatic logic [31:0] bits(int a, int b = -1);
        logic [31:0] m = '0;
        if (a >= 0) m[a] = 1'b1;
        if (b >= 0) m[b] = 1'b1;
        return m;
    endfunction

    task automatic drive(vec_t v);
        reset            = v.rstN;
        inDecodeValid    = v.dv;
        inUsesRs         = v.usesRs;
        inRegisterRs     = v.rs;
        inUsesRt         = v.usesRt;
        inRegisterRt     = v.rt;
        inMemReadEx      = v.memEx;
        inDestRegisterEx = v.destEx;
        inLoadIssue      = v.issue;
        inLoadDest       = v.loadDest;
        inLoadDone       = v.done;
        inLoadDoneDest   = v.doneDest;
        inBranchFlush    = v.flush;
    endtask

    task automatic check1(string name, logic [31:0] act, logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic checkRow(int idx, vec_t v);
        string tag;
        tag = $sformatf("row%0d_%s", idx, v.name);
        check1({tag, "_stall"}, {29'd0, outStallIf, outStallId, outBubbleEx}, {29'd0, {3{v.expStall}}});
        check1({tag, "_block"}, {31'd0, outIssueBlock}, {31'd0, v.expBlock});
        check1({tag, "_pending"}, outPending, v.expPend);
        check1({tag, "_state"}, {30'd0, dut.state}, {30'd0, v.expState});
    endtask

    initial begin
        vec_t idleV;
        idleV = mk("idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0, IDLE);
        drive(idleV);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        //          name        rst dv uRs rs uRt rt mem dEx iss ld dn dd fl  stall blk pend          state
        vecs.push_back(mk("rstGate",  0, 1, 1, 5, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, '0,          IDLE));
        vecs.push_back(mk("quiet",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0,          IDLE));
        vecs.push_back(mk("loadUse",  1, 1, 1, 5, 0, 0, 1, 5, 0, 0, 0, 0, 0, 1, 0, '0,          IDLE));
        vecs.push_back(mk("bubble",   1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0,          BUBBLE));
        vecs.push_back(mk("afterLU",  1, 1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0,          IDLE));
        vecs.push_back(mk("reg0",     1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, '0,          IDLE));
        vecs.push_back(mk("unusedRs", 1, 1, 0, 3, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, '0,          IDLE));
        vecs.push_back(mk("issue7",   1, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, '0,          IDLE));
        vecs.push_back(mk("mc1",      1, 1, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0, bits(7),     IDLE));
        vecs.push_back(mk("mc2",      1, 1, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0, bits(7),     WAIT));
        vecs.push_back(mk("mc3",      1, 1, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0, bits(7),     WAIT));
        vecs.push_back(mk("mcDone",   1, 1, 0, 0, 1, 7, 0, 0, 0, 0, 1, 7, 0, 0, 0, bits(7),     WAIT));
        vecs.push_back(mk("mcIdle",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0,          IDLE));
        vecs.push_back(mk("issue4",   1, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, '0,          IDLE));
        vecs.push_back(mk("issue6",   1, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 0, bits(4),     IDLE));
        vecs.push_back(mk("fullSwap", 1, 0, 0, 0, 0, 0, 0, 0, 1, 8, 1, 4, 0, 0, 1, bits(4, 6),  IDLE));
        vecs.push_back(mk("full68",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, bits(6, 8),  IDLE));
        vecs.push_back(mk("done6",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 1, bits(6, 8),  IDLE));
        vecs.push_back(mk("issue9",   1, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, bits(8),     IDLE));
        vecs.push_back(mk("race9",    1, 0, 0, 0, 0, 0, 0, 0, 1, 9, 1, 9, 0, 0, 1, bits(8, 9),  IDLE));
        vecs.push_back(mk("raceKeep", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, bits(8, 9),  IDLE));
        vecs.push_back(mk("done8",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 0, 0, 1, bits(8, 9),  IDLE));
        vecs.push_back(mk("pend9",    1, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, bits(9),     IDLE));
        vecs.push_back(mk("flush",    1, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, bits(9),     WAIT));
        vecs.push_back(mk("reHit",    1, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, bits(9),     IDLE));
        vecs.push_back(mk("wait9",    1, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, bits(9),     WAIT));
        vecs.push_back(mk("rstMid",   0, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0,          WAIT));
        vecs.push_back(mk("postRst",  1, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0,          IDLE));

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #3;
            checkRow(i, vecs[i]);
            @(posedge clk);
            #1;
        end

        // Flush wins over a load-use in the same cycle: no stall, FSM stays IDLE.
        drive(mk("luFlush", 1, 1, 0, 0, 1, 12, 1, 12, 0, 0, 0, 0, 1, 0, 0, '0, IDLE));
        #3;
        check1("luFlush_stall", {31'd0, outStallIf}, 32'd0);
        @(posedge clk);
        #1;
        check1("luFlush_state", {30'd0, dut.state}, {30'd0, IDLE});
        inBranchFlush = 1'b0;
        #3;
        check1("luNoFlush_stall", {29'd0, outStallIf, outStallId, outBubbleEx}, 32'd7);
        @(posedge clk);
        #1;
        check1("luNoFlush_state", {30'd0, dut.state}, {30'd0, BUBBLE});
        drive(idleV);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check1("luBack_state", {30'd0, dut.state}, {30'd0, IDLE});

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
